sblock_cfg_loader: RTL and testbench
====================================

Name: sblock_cfg_loader

Overview:
- Configuration writer for a bank of switch blocks. Each switch block holds 18 config bits (9 horizontal dot controls, then 9 vertical) in high-enable latches.
- Receives a serial bitstream over a valid/ready handshake and assembles one 18-bit word per block.
- Drives the shared config bus and a one-hot write enable, with setup/hold margin around each latch-open window.
- Sits between the chip-level bitstream source and the fabric's switch-block array.

Parameters:
- NUM_BLOCKS, 4, number of switch blocks programmed per load; must be ≥1.
- CFG_W, 18, config bits per block (9 dots × 2 bits).
- SETUP_CYC, 1, cycles the config bus is stable before the write enable rises; must be ≥1.
- WR_CYC, 2, cycles the write enable stays high; must be ≥1.
- HOLD_CYC, 1, cycles the config bus is stable after the write enable falls; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a full load; sampled in IDLE or DONE only
- bit_i  input  1  serial config bit
- bit_valid  input  1  bit_i is valid this cycle
- bit_ready  output  1  loader accepts bit_i this cycle
- cfg_bits  output  CFG_W  config word broadcast to all blocks' bits inputs
- wr_en  output  NUM_BLOCKS  one-hot write enable, bit k goes to block k
- busy  output  1  load in progress
- done  output  1  high from completion until the next start or reset

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; cfg_bits=0, wr_en=0, bit_ready=0, busy=0, done=0; bit and block counters cleared. Reset in any state, including mid-write, drops wr_en to 0 on the same edge.
- State machine: IDLE → SHIFT → SETUP → WRITE → HOLD → (SHIFT | DONE).
- IDLE/DONE:
  - start=1 → SHIFT, block_idx=0, bit_cnt=0, busy=1, done=0.
  - start in any other state is ignored.
- SHIFT:
  - bit_ready=1.
  - Each beat with bit_valid&bit_ready shifts the shift register left and inserts bit_i at the LSB. The first bit received ends at bit CFG_W-1, so it lands in dot_ctrl_H[8].
  - On the CFG_W-th accepted bit, go to SETUP. The complete word reaches cfg_bits in the same edge.
  - bit_valid=0 stalls the shift indefinitely with no timeout.
- cfg_bits changes only on the SHIFT→SETUP edge (or reset). It is never updated while wr_en≠0 or during HOLD.
- SETUP: bit_ready=0, wr_en=0, for SETUP_CYC cycles; then WRITE.
- WRITE: wr_en=1<<block_idx for exactly WR_CYC cycles; then HOLD. wr_en is never multi-hot.
- HOLD: wr_en=0 for HOLD_CYC cycles. Then:
  - If block_idx==NUM_BLOCKS-1 → DONE, busy=0, done=1.
  - Otherwise block_idx+1, bit_cnt=0 → SHIFT.
- Latency per block, from last accepted bit to re-entering SHIFT: SETUP_CYC+WR_CYC+HOLD_CYC cycles. Default is 4.
- Counters:
  - bit_cnt is $clog2(CFG_W+1) bits wide.
  - block_idx is max(1,$clog2(NUM_BLOCKS)) bits wide.
  - Neither wraps; both are cleared explicitly.
- Phase counter: one down-counter, reloaded at each SETUP/WRITE/HOLD entry.
- bit_ready is registered, high only in SHIFT; bits offered outside SHIFT are not consumed.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package sblock_cfg_pkg holds:
  - CFG_W = 18, DOT_N = 9.
  - State enum cfg_state_t {IDLE, SHIFT, SETUP, WRITE, HOLD, DONE}.
  - Field positions: H = [17:9], V = [8:0].
- One natural sub-module: cfg_shift_reg (CFG_W-bit serial-in/parallel-out with accept count and full flag). The FSM and timing stay in the top.

Test Plan:
- Single block (NUM_BLOCKS=1): start, then stream 18'h2A5C3 MSB-first with bit_valid held high. Required:
  - cfg_bits=18'h2A5C3 one cycle before wr_en=1'b1.
  - wr_en high for 2 cycles, bits stable 1 cycle after.
  - done=1 at cycle 18+4 after the first beat.
- Four blocks: stream 18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA. Required:
  - wr_en sequence 0001, 0010, 0100, 1000, each paired with the matching cfg_bits.
  - Never multi-hot.
  - done after the 4th HOLD.
- Stalls: randomly drop bit_valid, with 5-cycle gaps, inside the block-1 word. Required:
  - Identical written words to the un-stalled run.
  - bit_ready stays 1 during the gaps.
- Handshake outside SHIFT: hold bit_valid=1 through SETUP/WRITE/HOLD. Required: bit_ready=0 and no bits consumed. Block 2's word begins with the first beat after HOLD.
- Reset mid-WRITE: assert rst on the 2nd WRITE cycle of block 1. Required:
  - Next cycle wr_en=0, cfg_bits=0, busy=0, done=0, state IDLE.
  - A new start reloads from block 0.
- start while busy, and restart from DONE: pulse start in SHIFT → ignored, counters unchanged. After done=1, start → done=0, busy=1, block 0 is reprogrammed.

Source files
------------

// File: rtl/sblock_cfg_pkg.sv
// Shared definitions for the switch-block configuration loader: word layout,
// loader states and small sizing helpers.
package sblock_cfg_pkg;

  localparam int CFG_W = 18;
  localparam int DOT_N = 9;

  // Horizontal dot controls occupy the upper half, vertical the lower half.
  localparam int H_MSB = 2 * DOT_N - 1;
  localparam int H_LSB = DOT_N;
  localparam int V_MSB = DOT_N - 1;
  localparam int V_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETUP,
    WRITE,
    HOLD,
    DONE
  } cfg_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in/parallel-out assembler for one config word, MSB first, with a
// saturating accept counter and a full flag.
module cfg_shift_reg #(
  parameter int CFG_W = 18,
  parameter int CNT_W = $clog2(CFG_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_accept,
  input  logic             i_bit,
  output logic [CFG_W-1:0] o_word,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full
);

  logic [CFG_W-2:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_take;

  // o_word is the value the register holds after accepting i_bit this cycle.
  assign o_word = {r_sreg, i_bit};
  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == CNT_W'(CFG_W));
  assign w_take = i_accept && !o_full;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_take) begin
      r_sreg <= o_word[CFG_W-2:0];
    end
  end

endmodule

// File: rtl/sblock_cfg_loader.sv
// Loads one serial config word per switch block and writes it through a
// one-hot latch enable framed by setup and hold windows on the config bus.
module sblock_cfg_loader #(
  parameter int NUM_BLOCKS = 4,
  parameter int CFG_W      = sblock_cfg_pkg::CFG_W,
  parameter int SETUP_CYC  = 1,
  parameter int WR_CYC     = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_i,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [CFG_W-1:0]      cfg_bits,
  output logic [NUM_BLOCKS-1:0] wr_en,
  output logic                  busy,
  output logic                  done
);
  import sblock_cfg_pkg::*;

  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam int BLK_W = bits_for(NUM_BLOCKS);
  localparam int PH_W  = bits_for(max3(SETUP_CYC, WR_CYC, HOLD_CYC));

  cfg_state_t            r_state, w_state;
  logic [PH_W-1:0]       r_phase, w_phase;
  logic [BLK_W-1:0]      r_blk, w_blk;
  logic [CFG_W-1:0]      r_cfg, w_cfg;
  logic [NUM_BLOCKS-1:0] r_wr_en, w_wr_en;
  logic                  r_ready, w_ready;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_clr;
  logic                  w_accept;
  logic [CFG_W-1:0]      w_word;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_full;

  assign w_accept = bit_valid && r_ready && !w_full;

  cfg_shift_reg #(
    .CFG_W (CFG_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .i_clk    (clk),
    .i_clr    (rst || w_clr),
    .i_accept (w_accept),
    .i_bit    (bit_i),
    .o_word   (w_word),
    .o_cnt    (w_cnt),
    .o_full   (w_full)
  );

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_blk   = r_blk;
    w_cfg   = r_cfg;
    w_wr_en = '0;
    w_busy  = r_busy;
    w_done  = r_done;
    w_clr   = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state = SHIFT;
          w_blk   = '0;
          w_clr   = 1'b1;
          w_busy  = 1'b1;
          w_done  = 1'b0;
        end
      end
      SHIFT: begin
        if (w_accept && (w_cnt == CNT_W'(CFG_W - 1))) begin
          w_state = SETUP;
          w_cfg   = w_word;
          w_phase = PH_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (r_phase == '0) begin
          w_state = WRITE;
          w_phase = PH_W'(WR_CYC - 1);
          w_wr_en = NUM_BLOCKS'(1) << r_blk;
        end else begin
          w_phase = r_phase - 1'b1;
        end
      end
      WRITE: begin
        if (r_phase == '0) begin
          w_state = HOLD;
          w_phase = PH_W'(HOLD_CYC - 1);
        end else begin
          w_phase = r_phase - 1'b1;
          w_wr_en = r_wr_en;
        end
      end
      HOLD: begin
        if (r_phase != '0) begin
          w_phase = r_phase - 1'b1;
        end else if (r_blk == BLK_W'(NUM_BLOCKS - 1)) begin
          w_state = DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_state = SHIFT;
          w_blk   = r_blk + 1'b1;
          w_clr   = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    // Ready is registered, so it tracks the state being entered.
    w_ready = (w_state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_blk   <= '0;
      r_cfg   <= '0;
      r_wr_en <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_blk   <= w_blk;
      r_cfg   <= w_cfg;
      r_wr_en <= w_wr_en;
      r_ready <= w_ready;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bit_ready = r_ready;
  assign cfg_bits  = r_cfg;
  assign wr_en     = r_wr_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Scoreboard bench for the switch-block config loader: a 4-block and a 1-block
// instance share one bitstream source.
`timescale 1ns/1ps
module tb_sblock_cfg_loader;

  localparam int NB  = 4;
  localparam int CW  = 18;
  localparam int WRC = 2;

  logic clk = 1'b0;
  logic rst, start, bit_i, bit_valid;
  logic          rdy4, busy4, done4;
  logic [CW-1:0] cfg4;
  logic [NB-1:0] we4;
  logic          rdy1, busy1, done1;
  logic [CW-1:0] cfg1;
  logic [0:0]    we1;

  always #5 clk = ~clk;

  sblock_cfg_loader #(.NUM_BLOCKS(NB)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bit_i(bit_i), .bit_valid(bit_valid),
    .bit_ready(rdy4), .cfg_bits(cfg4), .wr_en(we4), .busy(busy4), .done(done4)
  );

  sblock_cfg_loader #(.NUM_BLOCKS(1)) u_one (
    .clk(clk), .rst(rst), .start(start), .bit_i(bit_i), .bit_valid(bit_valid),
    .bit_ready(rdy1), .cfg_bits(cfg1), .wr_en(we1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [NB-1:0] we;
    logic [CW-1:0] cfg;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] words[NB] = '{18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA};
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            t_first = 0;
  bit            mon_off = 1'b0;
  bit            u1_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_blocks(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.we  = NB'(1) << k;
      e.cfg = words[k];
      sb.push_back(e);
    end
  endtask

  // Junk is offered whenever the loader is not ready, so any wrongly consumed
  // beat corrupts the next written word.
  task automatic send_word(input logic [CW-1:0] w, input bit stall, input bit poke);
    int g;
    int s1;
    int s2;
    s1 = $urandom_range(1, 8);
    s2 = $urandom_range(9, 16);
    for (int i = CW - 1; i >= 0; i--) begin
      if (stall && (i == CW - 1 - s1 || i == CW - 1 - s2)) begin
        bit_valid = 1'b0;
        repeat (5) begin
          step();
          chk("rdy_gap", rdy4, 1);
        end
      end
      g = 0;
      while (!rdy4 && g < 100) begin
        bit_valid = 1'b1;
        bit_i = ~w[i];
        step();
        g++;
      end
      if (g >= 100) begin
        chk("rdy_timeout", rdy4, 1);
        return;
      end
      if (i == CW - 1) t_first = cyc;
      bit_valid = 1'b1;
      bit_i = w[i];
      if (poke && i == 9) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (!done4 && g < 200) begin
      step();
      g++;
    end
    chk({tag, "_done"}, done4, 1);
    chk({tag, "_busy"}, busy4, 0);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Scoreboard monitor for the 4-block instance.
  logic [NB-1:0] prev_we;
  logic [CW-1:0] prev_cfg, cur_cfg;
  int            len;
  always @(negedge clk) begin
    exp_t e;
    if (rst || mon_off) begin
      prev_we = '0;
      len = 0;
    end else begin
      if (we4 != '0) begin
        chk("onehot", $countones(we4), 1);
        chk("rdy_in_wr", rdy4, 0);
      end
      if (we4 != '0 && prev_we == '0) begin
        if (sb.size() == 0) begin
          chk("sb_pending", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("wr_en", we4, e.we);
          chk("cfg", cfg4, e.cfg);
          chk("setup_cfg", prev_cfg, e.cfg);
          cur_cfg = e.cfg;
        end
        len = 1;
      end else if (we4 != '0) begin
        len++;
        chk("cfg_stable", cfg4, cur_cfg);
      end else if (prev_we != '0) begin
        chk("wr_len", len, WRC);
        chk("hold_cfg", cfg4, cur_cfg);
      end
      prev_we = we4;
    end
    prev_cfg = cfg4;
  end

  // Timing monitor for the single-block instance.
  logic [0:0]    prev_we1;
  logic [CW-1:0] prev_cfg1;
  logic          prev_done1;
  int            len1;
  always @(negedge clk) begin
    if (u1_on) begin
      if (we1 == 1'b1 && prev_we1 == 1'b0) begin
        chk("u1_cfg", cfg1, 18'h2A5C3);
        chk("u1_setup_cfg", prev_cfg1, 18'h2A5C3);
        len1 = 1;
      end else if (we1 == 1'b1) begin
        len1++;
      end else if (prev_we1 == 1'b1) begin
        chk("u1_wr_len", len1, WRC);
        chk("u1_hold_cfg", cfg1, 18'h2A5C3);
      end
      if (done1 && !prev_done1) begin
        chk("u1_done_cyc", cyc - t_first, CW + 4);
        chk("u1_busy", busy1, 0);
      end
    end
    prev_we1 = we1;
    prev_cfg1 = cfg1;
    prev_done1 = done1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    rst = 1'b1;
    start = 1'b0;
    bit_i = 1'b0;
    bit_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_cfg", cfg4, 0);
    chk("rst_we", we4, 0);
    chk("rst_rdy", rdy4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_u1_rdy", rdy1, 0);
    chk("rst_u1_done", done1, 0);

    // Single block word on the 1-block instance; the 4-block one writes block 0.
    pulse_start();
    chk("t1_busy", busy1, 1);
    chk("t1_rdy", rdy1, 1);
    u1_on = 1'b1;
    begin
      exp_t e;
      e.we = NB'(1);
      e.cfg = 18'h2A5C3;
      sb.push_back(e);
    end
    send_word(18'h2A5C3, 1'b0, 1'b0);
    g = 0;
    while (!done1 && g < 40) begin
      step();
      g++;
    end
    chk("u1_done", done1, 1);
    chk("t1_sb_left", sb.size(), 0);
    u1_on = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Four blocks back to back, junk offered while not ready.
    pulse_start();
    chk("t2_busy", busy4, 1);
    chk("t2_done", done4, 0);
    push_blocks(NB);
    for (int k = 0; k < NB; k++) send_word(words[k], 1'b0, 1'b0);
    wait_done("t2");

    // Restart from DONE, stalls and a stray start inside block 1.
    pulse_start();
    chk("t3_restart_done", done4, 0);
    chk("t3_restart_busy", busy4, 1);
    push_blocks(NB);
    for (int k = 0; k < NB; k++) send_word(words[k], k == 1, k == 1);
    wait_done("t3");

    // Reset on the second WRITE cycle of block 1.
    pulse_start();
    push_blocks(2);
    send_word(words[0], 1'b0, 1'b0);
    send_word(words[1], 1'b0, 1'b0);
    g = 0;
    while (we4 != 4'b0010 && g < 20) begin
      step();
      g++;
    end
    chk("t4_wr1", we4, 4'b0010);
    mon_off = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_we", we4, 0);
    chk("t4_cfg", cfg4, 0);
    chk("t4_busy", busy4, 0);
    chk("t4_done", done4, 0);
    chk("t4_rdy", rdy4, 0);
    chk("t4_sb_left", sb.size(), 0);
    mon_off = 1'b0;
    step();
    pulse_start();
    push_blocks(NB);
    for (int k = 0; k < NB; k++) send_word(words[k], 1'b0, 1'b0);
    wait_done("t4b");

    bit_valid = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
